tilt_move_gen: RTL and testbench

- Producer side of the ball's `movement[3:0]` interface.
- Converts signed accelerometer tilt samples into one-hot, single-cycle movement pulses.
- Pulse rate is proportional to tilt magnitude; a dead-zone suppresses small tilts.
- Pulses are spaced so the ball's collision scan always completes before the next request; the block sits between the accelerometer SPI front-end and the ball logic.

---
 rtl/labyrinth_pkg.sv | 23 ++
 rtl/tilt_move_gen_axis.sv | 68 ++++++
 rtl/tilt_move_gen.sv | 159 +++++++++++++++
 tb/tb_tilt_move_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/labyrinth_pkg.sv
// rtl/labyrinth_pkg.sv - movement codes, arbiter states and level limit shared with the ball logic
package labyrinth_pkg;

  localparam logic [3:0] MOVE_NONE  = 4'b0000;
  localparam logic [3:0] MOVE_UP    = 4'b0001;
  localparam logic [3:0] MOVE_DOWN  = 4'b0010;
  localparam logic [3:0] MOVE_LEFT  = 4'b0100;
  localparam logic [3:0] MOVE_RIGHT = 4'b1000;

  localparam logic [3:0] LEVEL_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } move_state_e;

  // -2048 maps to 12'h800, which is still correct read as unsigned
  function automatic logic [11:0] abs12(input logic [11:0] s);
    return s[11] ? (~s + 12'd1) : s;
  endfunction

endpackage

// File: rtl/tilt_move_gen_axis.sv
// rtl/tilt_move_gen_axis.sv - tilt_axis_rate: per-axis dead-zone, speed level, rate accumulator and pending flag
module tilt_axis_rate
  import labyrinth_pkg::*;
#(
  parameter int DEADZONE    = 64,
  parameter int SPEED_SHIFT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [11:0] sample,
  input  logic        clr_pending,
  output logic        pending,
  output logic        dir_pos
);

  logic [11:0] mag;
  logic [11:0] excess;
  logic [11:0] steps;
  logic        active;
  logic [3:0]  level;
  logic [4:0]  sum;
  logic [3:0]  acc_q, acc_d;
  logic        pending_q, pending_d;
  logic        dir_pos_q, dir_pos_d;

  always_comb begin
    mag    = abs12(sample);
    active = (mag > 12'(DEADZONE));
    excess = mag - 12'(DEADZONE);
    steps  = excess >> SPEED_SHIFT;
    level  = (steps >= (12'(LEVEL_MAX) - 12'd1)) ? LEVEL_MAX : (steps[3:0] + 4'd1);
    sum    = {1'b0, acc_q} + {1'b0, level};

    acc_d     = acc_q;
    dir_pos_d = dir_pos_q;
    pending_d = pending_q & ~clr_pending;
    // A carry landing on the clearing cycle re-arms the flag; a carry onto a held flag is dropped
    if (tick) begin
      if (active) begin
        acc_d = sum[3:0];
        if (sum[4] && !pending_d) begin
          pending_d = 1'b1;
          dir_pos_d = ~sample[11];
        end
      end else begin
        acc_d     = 4'd0;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q     <= 4'd0;
      pending_q <= 1'b0;
      dir_pos_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      pending_q <= pending_d;
      dir_pos_q <= dir_pos_d;
    end
  end

  assign pending = pending_q;
  assign dir_pos = dir_pos_q;

endmodule

// File: rtl/tilt_move_gen.sv
// rtl/tilt_move_gen.sv - tilt samples to spaced one-hot movement pulses; ACCEL_TIMEOUT_EN zeroes stale samples
module tilt_move_gen
  import labyrinth_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int TICK_HZ                = 240,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int DEADZONE               = 64,
  parameter int SPEED_SHIFT            = 7,
  parameter int GAP_CYCLES             = 64,
  parameter int TIMEOUT_TICKS          = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  input  logic        accel_valid,
  output logic [3:0]  movement,
  output logic        busy
);

  localparam int DIV = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT : (CLK_FREQUENCY_HZ / TICK_HZ);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  logic [31:0]    tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [11:0]    x_q, x_d, y_q, y_d;
  logic           x_pend, y_pend, x_dir_pos, y_dir_pos;
  logic           clr_x, clr_y;
`ifdef ACCEL_TIMEOUT_EN
  logic [31:0]    stale_q, stale_d;
`endif
  move_state_e    state_q, state_d;
  logic [3:0]     movement_q, movement_d;
  logic           busy_q, busy_d;
  logic           sel_y_q, sel_y_d;
  logic           rr_y_q, rr_y_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == 32'(DIV - 1));
    tick_cnt_d = tick ? 32'd0 : (tick_cnt_q + 32'd1);
    x_d        = x_q;
    y_d        = y_q;
`ifdef ACCEL_TIMEOUT_EN
    stale_d = stale_q;
    if (accel_valid) begin
      stale_d = 32'd0;
    end else if (tick && (stale_q < 32'(TIMEOUT_TICKS))) begin
      stale_d = stale_q + 32'd1;
    end
    if (!accel_valid && (stale_q == 32'(TIMEOUT_TICKS))) begin
      x_d = 12'd0;
      y_d = 12'd0;
    end
`endif
    if (accel_valid) begin
      x_d = accel_x;
      y_d = accel_y;
    end
  end

  tilt_axis_rate #(.DEADZONE(DEADZONE), .SPEED_SHIFT(SPEED_SHIFT)) u_axis_x (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sample      (x_q),
    .clr_pending (clr_x),
    .pending     (x_pend),
    .dir_pos     (x_dir_pos)
  );

  tilt_axis_rate #(.DEADZONE(DEADZONE), .SPEED_SHIFT(SPEED_SHIFT)) u_axis_y (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sample      (y_q),
    .clr_pending (clr_y),
    .pending     (y_pend),
    .dir_pos     (y_dir_pos)
  );

  assign clr_x = (state_q == PULSE) && !sel_y_q;
  assign clr_y = (state_q == PULSE) &&  sel_y_q;

  // The IDLE cycle counts as the last idle cycle, so GAP lasts GAP_CYCLES-1 and pulses sit GAP_CYCLES+1 apart
  always_comb begin
    state_d    = state_q;
    movement_d = MOVE_NONE;
    sel_y_d    = sel_y_q;
    rr_y_d     = rr_y_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (x_pend || y_pend) begin
          state_d    = PULSE;
          sel_y_d    = y_pend && (!x_pend || rr_y_q);
          movement_d = sel_y_d ? (y_dir_pos ? MOVE_DOWN  : MOVE_UP)
                               : (x_dir_pos ? MOVE_RIGHT : MOVE_LEFT);
        end
      end
      PULSE: begin
        state_d   = GAP;
        rr_y_d    = ~sel_y_q;
        gap_cnt_d = GCW'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt_q <= GCW'(1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q <= 32'd0;
      x_q        <= 12'd0;
      y_q        <= 12'd0;
`ifdef ACCEL_TIMEOUT_EN
      stale_q    <= 32'd0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
`ifdef ACCEL_TIMEOUT_EN
      stale_q    <= stale_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      movement_q <= MOVE_NONE;
      busy_q     <= 1'b0;
      sel_y_q    <= 1'b0;
      rr_y_q     <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      movement_q <= movement_d;
      busy_q     <= busy_d;
      sel_y_q    <= sel_y_d;
      rr_y_q     <= rr_y_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign movement = movement_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tilt_move_gen.sv
// tb/tb_tilt_move_gen.sv - directed bench for tilt_move_gen with SIMULATE=1, 5 cycles per tick
module tb_tilt_move_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] accel_x = 12'd0;
  logic [11:0] accel_y = 12'd0;
  logic        accel_valid = 1'b0;
  logic [3:0]  movement;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tilt_move_gen #(
    .CLK_FREQUENCY_HZ       (100000000),
    .TICK_HZ                (240),
    .SIMULATE               (1),
    .SIMULATE_FREQUENCY_CNT (5),
    .DEADZONE               (64),
    .SPEED_SHIFT            (7),
    .GAP_CYCLES             (64),
    .TIMEOUT_TICKS          (48)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_valid (accel_valid),
    .movement    (movement),
    .busy        (busy)
  );

  task automatic strobe(input logic [11:0] x, input logic [11:0] y);
    accel_x     = x;
    accel_y     = y;
    accel_valid = 1'b1;
    @(negedge clk);
    accel_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    accel_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_pulse(input int max_cycles, output int cyc, output logic [3:0] mv);
    cyc = -1;
    mv  = 4'd0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (movement !== 4'd0) begin
        cyc = i;
        mv  = movement;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [3:0] mv;
    reset       = 1'b0;
    accel_x     = 12'd1000;
    accel_y     = 12'd0;
    accel_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== 4'd0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: movement=%b busy=%b, want 0000/0", i, movement, busy);
      end
    end
    reset = 1'b1;
    strobe(12'd1000, 12'd0);
    wait_pulse(40, cyc, mv);
    vectors++;
    if (cyc !== 10 || mv !== 4'b1000) begin
      miscompares++;
      $display("FAIL first_pulse: cycle=%0d mv=%b, want cycle 10 mv 1000", cyc, mv);
    end
    @(negedge clk);
    vectors++;
    if (movement !== 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_pulse_width: movement=%b busy=%b, want 0000/1", movement, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [3:0] mv;
    do_reset();
    strobe(12'd1000, 12'd0);
    wait_pulse(40, cyc, mv);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (movement !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_pulse: movement=%b busy=%b, want 0000/0", movement, busy);
    end
    reset = 1'b1;
    wait_pulse(30, cyc, mv);
    vectors++;
    if (cyc !== -1) begin
      miscompares++;
      $display("FAIL after_mid_pulse_reset: pulse at cycle %0d, want none", cyc);
    end
    do_reset();
    strobe(12'd1000, 12'd0);
    wait_pulse(40, cyc, mv);
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_gap: busy=%b, want 1", busy);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (movement !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_gap: movement=%b busy=%b, want 0000/0", movement, busy);
    end
    reset = 1'b1;
    wait_pulse(30, cyc, mv);
    vectors++;
    if (cyc !== -1) begin
      miscompares++;
      $display("FAIL after_mid_gap_reset: pulse at cycle %0d, want none", cyc);
    end
  endtask

  task automatic test_deadzone();
    int cyc;
    logic [3:0] mv;
    do_reset();
    strobe(12'd64, 12'hFC0);
    wait_pulse(300, cyc, mv);
    vectors++;
    if (cyc !== -1) begin
      miscompares++;
      $display("FAIL deadzone: pulse mv=%b at cycle %0d, want none", mv, cyc);
    end
  endtask

  task automatic test_min_level();
    int cyc;
    logic [3:0] mv;
    do_reset();
    strobe(12'd65, 12'd0);
    wait_pulse(120, cyc, mv);
    vectors++;
    if (cyc !== 80 || mv !== 4'b1000) begin
      miscompares++;
      $display("FAIL level1_first: cycle=%0d mv=%b, want 80/1000", cyc, mv);
    end
    @(negedge clk);
    vectors++;
    if (movement !== 4'd0) begin
      miscompares++;
      $display("FAIL level1_width: movement=%b, want 0000", movement);
    end
    wait_pulse(120, cyc, mv);
    vectors++;
    if (cyc !== 79 || mv !== 4'b1000) begin
      miscompares++;
      $display("FAIL level1_period: cycle=%0d mv=%b, want 79/1000", cyc, mv);
    end
  endtask

  task automatic test_gap_limited();
    int cyc;
    logic [3:0] mv;
    do_reset();
    strobe(12'hC18, 12'd0);
    wait_pulse(40, cyc, mv);
    vectors++;
    if (cyc !== 10 || mv !== 4'b0100) begin
      miscompares++;
      $display("FAIL left_first: cycle=%0d mv=%b, want 10/0100", cyc, mv);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (movement !== 4'd0) begin
        miscompares++;
        $display("FAIL left_width[%0d]: movement=%b, want 0000", k, movement);
      end
      wait_pulse(100, cyc, mv);
      vectors++;
      if (cyc !== 64 || mv !== 4'b0100) begin
        miscompares++;
        $display("FAIL left_spacing[%0d]: cycle=%0d mv=%b, want 64/0100", k, cyc, mv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] mv;
    logic [3:0] want [4];
    want[0] = 4'b1000;
    want[1] = 4'b0010;
    want[2] = 4'b1000;
    want[3] = 4'b0010;
    do_reset();
    strobe(12'd1000, 12'd1000);
    wait_pulse(40, cyc, mv);
    vectors++;
    if (cyc !== 10 || mv !== want[0]) begin
      miscompares++;
      $display("FAIL rr_first: cycle=%0d mv=%b, want 10/%b", cyc, mv, want[0]);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      wait_pulse(100, cyc, mv);
      vectors++;
      if (cyc !== 64 || mv !== want[k]) begin
        miscompares++;
        $display("FAIL rr_seq[%0d]: cycle=%0d mv=%b, want 64/%b", k, cyc, mv, want[k]);
      end
    end
  endtask

  task automatic test_stale();
    int n;
    int last;
    int cyc;
    logic [3:0] mv;
    n    = 0;
    last = 0;
    do_reset();
    strobe(12'd1000, 12'd0);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (movement !== 4'd0) begin
        n++;
        last = i;
      end
    end
`ifdef ACCEL_TIMEOUT_EN
    vectors++;
    if (n !== 4 || last !== 205) begin
      miscompares++;
      $display("FAIL timeout_stop: pulses=%0d last=%0d, want 4/205", n, last);
    end
    strobe(12'd1000, 12'd0);
    wait_pulse(30, cyc, mv);
    vectors++;
    if (cyc !== 9 || mv !== 4'b1000) begin
      miscompares++;
      $display("FAIL timeout_resume: cycle=%0d mv=%b, want 9/1000", cyc, mv);
    end
`else
    vectors++;
    if (n !== 7 || last !== 400) begin
      miscompares++;
      $display("FAIL sample_hold: pulses=%0d last=%0d, want 7/400", n, last);
    end
    wait_pulse(70, cyc, mv);
    vectors++;
    if (cyc !== 65 || mv !== 4'b1000) begin
      miscompares++;
      $display("FAIL sample_hold_next: cycle=%0d mv=%b, want 65/1000", cyc, mv);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_deadzone();
    test_min_level();
    test_gap_limited();
    test_back_to_back();
    test_stale();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
